mac_audio_out: RTL

Audio output stage downstream of the data controller; consumes its 11-bit unsigned volume-scaled sample (audioOut) each time a new sound byte is latched.
- Removes the DC offset and converts the sample to signed 16-bit PCM for the HDMI/I2S path.
- Applies a one-pole low-pass to soften 22 kHz stair-steps.
- Drives a first-order 1-bit sigma-delta DAC for the analog pin.

---
 rtl/mac_audio_out.sv | 87 ++++++++
 1 files changed

// File: rtl/mac_audio_out.sv
// Audio output stage: DC removal, 16-bit signed PCM, one-pole low-pass and a
// first-order 1-bit sigma-delta DAC for the analog pin.
module mac_audio_out #(
  parameter int unsigned DC_SHIFT  = 10,
  parameter int unsigned LPF_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cep,
  input  logic [10:0] sample_in,
  input  logic        sample_valid,
  input  logic        mute,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  output logic        dac_out
);

  localparam int unsigned DcW = 11 + DC_SHIFT;

  logic [DcW-1:0]     dc_acc_q, dc_acc_d;
  logic [10:0]        dc_est;
  logic signed [11:0] ac_q, ac_d;
  logic signed [15:0] y_q, y_d;
  logic signed [15:0] target;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic [15:0]        sd_q, sd_d;
  logic [16:0]        sd_sum;
  logic               dac_q, dac_d;
  logic               pcm_valid_q, pcm_valid_d;
  logic               accept;

  assign accept = cep & sample_valid;

  // dc_acc is bounded by 2047 << DC_SHIFT, so the modular sum never wraps in the final value.
  always_comb begin
    dc_est      = 11'(dc_acc_q >> DC_SHIFT);
    dc_acc_d    = dc_acc_q;
    ac_d        = ac_q;
    pcm_valid_d = accept;
    if (accept) begin
      dc_acc_d = dc_acc_q + DcW'(sample_in) - DcW'(dc_est);
      ac_d     = $signed({1'b0, sample_in}) - $signed({1'b0, dc_est});
    end
  end

  // Low-pass runs on the ac value registered before this edge.
  always_comb begin
    target = mute ? 16'sd0 : {ac_q, 4'b0000};
    diff   = {target[15], target} - {y_q[15], y_q};
    step   = diff >>> LPF_SHIFT;
    y_d    = y_q;
    if (cep) begin
      y_d = y_q + 16'(step);
    end
  end

  // Offset-binary input: the carry density tracks (pcm + 32768) / 65536.
  always_comb begin
    sd_sum = {1'b0, sd_q} + {1'b0, y_q ^ 16'h8000};
    sd_d   = sd_sum[15:0];
    dac_d  = sd_sum[16];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_acc_q    <= '0;
      ac_q        <= '0;
      y_q         <= '0;
      sd_q        <= '0;
      dac_q       <= 1'b0;
      pcm_valid_q <= 1'b0;
    end else begin
      dc_acc_q    <= dc_acc_d;
      ac_q        <= ac_d;
      y_q         <= y_d;
      sd_q        <= sd_d;
      dac_q       <= dac_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_out   = y_q;
  assign pcm_valid = pcm_valid_q;
  assign dac_out   = dac_q;

endmodule
